// File: rtl/weight_mem_q14.sv
// weight_mem_q14
// ---------------------------------------------------------------------------
// Weight store for the Q14 plasticity path. Holds F*N signed 16-bit weights
// in a single-port array, addressed row-major (addr = f*N + n). The array
// performs at most one access per cycle.
//
// After reset, or on an init_req pulse, the block runs a fill pass that
// writes INIT_W to every word, one word per cycle, with busy held high.
// Outside a fill pass, the learn port has priority over the host port.
//
// Ports
//   clk         clock; all logic runs on the rising edge
//   rst_n       synchronous active-low reset
//   init_req    pulse that starts a fill pass (ignored while busy)
//   busy        high while a fill pass is in progress
//   l_re/l_we   learn-port read / write strobes
//   l_addr      learn-port address
//   l_wdata     learn-port write data
//   l_rdata     learn-port read data, valid with l_rvalid (1-cycle latency)
//   l_rvalid    learn-port read-data valid pulse
//   h_valid     host request valid; the host holds its fields until accepted
//   h_ready     host request accepted when h_valid && h_ready
//   h_write     host request type: 1 = write, 0 = read
//   h_addr      host address
//   h_wdata     host write data
//   h_rvalid    host read-data valid pulse, 1 cycle after an accepted read
//   h_rdata     host read data
//   err_collide sticky flag: l_re and l_we were asserted together
//   err_oor     sticky flag: an accepted access used an address >= F*N
//   l_wr_count  number of performed learn writes, saturating
// ---------------------------------------------------------------------------
module weight_mem_q14 #(
  parameter int F = 48,
  parameter int N = 96,
  parameter logic signed [15:0] INIT_W = 16'sd0,
  localparam int AW = (F*N <= 1) ? 1 : $clog2(F*N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init_req,
  output logic          busy,
  input  logic          l_re,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [15:0]   l_wdata,
  output logic [15:0]   l_rdata,
  output logic          l_rvalid,
  input  logic          h_valid,
  output logic          h_ready,
  input  logic          h_write,
  input  logic [AW-1:0] h_addr,
  input  logic [15:0]   h_wdata,
  output logic          h_rvalid,
  output logic [15:0]   h_rdata,
  output logic          err_collide,
  output logic          err_oor,
  output logic [31:0]   l_wr_count
);

  localparam int DEPTH = F * N;
  localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] fill_ptr, fill_nxt;

  logic [15:0]   mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [15:0]   mem_wdata;

  logic          run;
  logic          l_in_rng, h_in_rng;
  logic          l_wr, l_rd, l_col;
  logic          h_acc, h_wr, h_rd;
  logic [AW-1:0] rd_addr;
  logic          rd_in_rng;
  logic [15:0]   rd_word;
  logic          oor_hit;

  // Access decode. Learn strobes only act in S_RUN; a simultaneous l_re and
  // l_we performs only the write. The host is accepted only when the learn
  // port leaves the array idle.
  assign run      = (state == S_RUN);
  assign busy     = (state == S_INIT);
  assign l_in_rng = ({1'b0, l_addr} < DEPTH_X);
  assign h_in_rng = ({1'b0, h_addr} < DEPTH_X);
  assign l_wr     = run && l_we;
  assign l_rd     = run && l_re && !l_we;
  assign l_col    = run && l_re && l_we;
  assign h_ready  = run && !l_re && !l_we;
  assign h_acc    = h_valid && h_ready;
  assign h_wr     = h_acc && h_write;
  assign h_rd     = h_acc && !h_write;

  // Learn and host reads are mutually exclusive, so one read port serves both.
  // Out-of-range reads return zero without touching the array.
  assign rd_addr   = l_rd ? l_addr : h_addr;
  assign rd_in_rng = l_rd ? l_in_rng : h_in_rng;
  assign rd_word   = rd_in_rng ? mem[rd_addr] : 16'h0000;
  assign oor_hit   = ((l_wr || l_rd) && !l_in_rng) || (h_acc && !h_in_rng);

  // State and fill-pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_INIT;
      fill_ptr <= '0;
    end else begin
      state    <= state_nxt;
      fill_ptr <= fill_nxt;
    end
  end

  // Next state plus the array write mux. In S_RUN an init_req still lets the
  // same-cycle learn or host access through; the fill starts next cycle.
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_ptr;
    mem_we    = 1'b0;
    mem_waddr = fill_ptr;
    mem_wdata = INIT_W;
    case (state)
      S_INIT: begin
        mem_we = 1'b1;
        if (fill_ptr == LAST_PTR) begin
          state_nxt = S_RUN;
          fill_nxt  = '0;
        end else begin
          fill_nxt = fill_ptr + 1'b1;
        end
      end
      S_RUN: begin
        if (init_req) begin
          state_nxt = S_INIT;
          fill_nxt  = '0;
        end
        if (l_wr && l_in_rng) begin
          mem_we    = 1'b1;
          mem_waddr = l_addr;
          mem_wdata = l_wdata;
        end else if (h_wr && h_in_rng) begin
          mem_we    = 1'b1;
          mem_waddr = h_addr;
          mem_wdata = h_wdata;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // Storage array; contents are defined by the fill pass, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read data, valid pulses, sticky flags and the write counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      l_rvalid    <= 1'b0;
      h_rvalid    <= 1'b0;
      l_rdata     <= '0;
      h_rdata     <= '0;
      err_collide <= 1'b0;
      err_oor     <= 1'b0;
      l_wr_count  <= '0;
    end else begin
      l_rvalid <= l_rd;
      h_rvalid <= h_rd;
      if (l_rd) begin
        l_rdata <= rd_word;
      end
      if (h_rd) begin
        h_rdata <= rd_word;
      end
      if (l_col) begin
        err_collide <= 1'b1;
      end
      if (oor_hit) begin
        err_oor <= 1'b1;
      end
      if (l_wr && l_in_rng && (l_wr_count != 32'hFFFF_FFFF)) begin
        l_wr_count <= l_wr_count + 32'd1;
      end
    end
  end

endmodule

// File: doc/weight_mem_q14.md
Name: weight_mem_q14

Overview:
- Weight store for the Q14 plasticity path: F×N signed 16-bit weights in one single-port array, addressed row-major (addr = f*N + n).
- Serves the STDP learner's read/write port (learn port) with 1-cycle read latency.
- Also serves a host load/readback port with a valid/ready handshake.
- Runs a self-clear (fill with INIT_W) after reset or on request.

Parameters:
- F, 48, number of presynaptic features (rows).
- N, 96, number of postsynaptic neurons (columns).
- INIT_W, 0, signed 16-bit fill value written to every word during init.
- AW, localparam = (F*N <= 1) ? 1 : $clog2(F*N), address width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- init_req  in  1  pulse: start a fill pass (ignored while busy).
- busy  out  1  high during a fill pass.
- l_re  in  1  learn-port read strobe.
- l_we  in  1  learn-port write strobe.
- l_addr  in  AW  learn-port address.
- l_wdata  in  16  learn-port write data (signed Q14).
- l_rdata  out  16  learn-port read data (signed), valid with l_rvalid.
- l_rvalid  out  1  read data valid, 1 cycle after an accepted l_re.
- h_valid  in  1  host request valid.
- h_ready  out  1  host request accepted when h_valid && h_ready.
- h_write  in  1  1 = write, 0 = read.
- h_addr  in  AW  host address.
- h_wdata  in  16  host write data.
- h_rvalid  out  1  host read data valid, 1 cycle after an accepted host read.
- h_rdata  out  16  host read data.
- err_collide  out  1  sticky: l_re and l_we asserted in the same cycle.
- err_oor  out  1  sticky: any accepted access with addr >= F*N.
- l_wr_count  out  32  count of performed learn-port writes, saturating at 0xFFFF_FFFF.

Behaviour:
- Reset (rst_n=0 at posedge):
  - busy=1, fill pointer=0.
  - l_rvalid=0, h_rvalid=0, l_rdata=0, h_rdata=0.
  - err_collide=0, err_oor=0, l_wr_count=0, state=S_INIT.
  - Array contents are not reset directly; the fill pass defines them.
- Reset asserted mid-fill or mid-access: the pass restarts from address 0. No pending rvalid survives reset.
- States:
  - S_INIT: writes INIT_W at the fill pointer, one word per cycle.
    - At pointer F*N-1: go to S_RUN and drop busy the next cycle. A fill therefore takes exactly F*N cycles.
    - While in S_INIT, h_ready=0 and learn strobes are ignored: no write, no l_rvalid, no error flags, no count.
  - S_RUN: one array access per cycle. Priority is learn port over host port.
    - init_req=1 in S_RUN: go to S_INIT with pointer 0 next cycle.
    - If init_req and a learn strobe arrive in the same cycle, the learn access is still performed that cycle.
- Learn port:
  - l_we: write l_wdata at l_addr this cycle. Increments l_wr_count.
  - l_re: read l_addr. l_rdata/l_rvalid are registered and appear exactly 1 cycle later. l_rvalid is a 1-cycle pulse per read.
  - Back-to-back reads are fully pipelined, one per cycle.
  - Write at A in cycle t, then read A in cycle t+1: returns the new value.
  - l_re && l_we together: only the write is performed, l_rvalid stays 0 next cycle, err_collide is set.
- Host port:
  - h_ready = (state==S_RUN) && !l_re && !l_we. It is combinational from the learn strobes.
  - Accepted host write stores h_wdata raw (no clamp).
  - Accepted host read drives h_rdata/h_rvalid 1 cycle later.
  - The host holds h_valid and its fields stable until accepted.
- Out-of-range address (addr >= F*N), either port, only when the access is accepted/performed:
  - Write is dropped and l_wr_count is not incremented.
  - Read returns 0 with rvalid asserted normally.
  - err_oor is set.
- Sticky flags clear only on reset.
- Data is stored and returned bit-exact; no arithmetic on the data path.

Test Plan:
- F=4, N=3, INIT_W=16'sh0100: release reset -> busy=1 for exactly 12 cycles. Host reads of addr 0..11 all return 0x0100 with h_rvalid 1 cycle after each accept.
- Learn write addr 5 = 16'sh8000 at cycle t, l_re addr 5 at t+1 -> l_rdata=0x8000, l_rvalid=1 at t+2. l_wr_count=1.
- Host read of addr 2 held with h_valid=1 while learn strobes are active for 3 cycles -> h_ready=0 for those 3 cycles. The read is accepted on the first idle cycle and the data appears 1 cycle later.
- l_re=l_we=1, addr 7, wdata 0x1234 -> addr 7 reads back 0x1234. No l_rvalid in the collision cycle+1. err_collide=1 and stays 1.
- Learn write to addr 12 (F*N) and host read of addr 15 -> no array change, h_rdata=0 with h_rvalid=1, err_oor=1, l_wr_count unchanged.
- rst_n=0 for one cycle at fill pointer 6 -> busy stays 1 and the fill restarts at 0, taking 12 more cycles. init_req in S_RUN after host writes -> all words return INIT_W again.
